// File: rtl/decode_regread_pkg.sv
// -----------------------------------------------------------------------------
// decode_regread_pkg
// Shared widths and the D->E pipeline-register bundle used by the decode /
// register-read stage and reused by neighbouring pipeline-register stages.
//   XLEN       : data width of registers and the result bus
//   NREGS      : number of architectural integer registers
//   REG_ADDR_W : register address width
//   de_reg_t   : D->E register contents (operands, register ids, valid)
// -----------------------------------------------------------------------------
package decode_regread_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef struct packed {
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  valid;
    } de_reg_t;

endpackage

// File: rtl/reg_file_2r1w.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// Architectural integer register file: two combinational read ports, one
// synchronous write port. x0 always reads zero and ignores writes. A write
// presented in the same cycle as a read of the same register is passed
// straight through to the read port (write-through bypass).
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears all regs)
//   we/waddr/wdata  : write port
//   raddr1/rdata1   : read port 1
//   raddr2/rdata2   : read port 2
// -----------------------------------------------------------------------------
module reg_file_2r1w
    import decode_regread_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]       rdata1,
    output logic [XLEN-1:0]       rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    // NOTE: this array is reset on purpose (architectural state must start at
    // zero), so it maps to flops rather than a RAM macro without reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Priority: x0 -> same-cycle writeback -> stored value.
    assign rdata1 = (raddr1 == '0)              ? '0    :
                    (we && waddr == raddr1)     ? wdata :
                                                  regs[raddr1];
    assign rdata2 = (raddr2 == '0)              ? '0    :
                    (we && waddr == raddr2)     ? wdata :
                                                  regs[raddr2];

endmodule

// File: rtl/decode_regread.sv
// -----------------------------------------------------------------------------
// decode_regread
// Decode-stage register read plus the D->E pipeline register.
// Holds the register file (written by the writeback stage), reads the two
// decode operands with write-through bypass, and registers them into E with
// flush (bubble) and stall (hold) control. While stalled, a held operand is
// refreshed if its source register is written back, so a long stall cannot
// leave a stale value in E.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   RegWriteW_i/RdW_i/ResultW_i   : writeback port
//   Rs1D_i/Rs2D_i/RdD_i/ValidD_i  : decode slot
//   StallE_i/FlushE_i             : E register hold / bubble insert
//   RD1E_o..ValidE_o              : registered E-stage fields
// -----------------------------------------------------------------------------
module decode_regread
    import decode_regread_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW_i,
    input  logic [REG_ADDR_W-1:0] RdW_i,
    input  logic [XLEN-1:0]       ResultW_i,
    input  logic [REG_ADDR_W-1:0] Rs1D_i,
    input  logic [REG_ADDR_W-1:0] Rs2D_i,
    input  logic [REG_ADDR_W-1:0] RdD_i,
    input  logic                  ValidD_i,
    input  logic                  StallE_i,
    input  logic                  FlushE_i,
    output logic [XLEN-1:0]       RD1E_o,
    output logic [XLEN-1:0]       RD2E_o,
    output logic [REG_ADDR_W-1:0] Rs1E_o,
    output logic [REG_ADDR_W-1:0] Rs2E_o,
    output logic [REG_ADDR_W-1:0] RdE_o,
    output logic                  ValidE_o
);

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    de_reg_t         e_q;
    logic            refresh1;
    logic            refresh2;

    reg_file_2r1w u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWriteW_i),
        .waddr  (RdW_i),
        .wdata  (ResultW_i),
        .raddr1 (Rs1D_i),
        .raddr2 (Rs2D_i),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // A writeback to a register held in a stalled E slot replaces the
    // operand captured earlier. x0 is excluded: its operand stays zero.
    assign refresh1 = RegWriteW_i && (RdW_i != '0) && (RdW_i == e_q.rs1);
    assign refresh2 = RegWriteW_i && (RdW_i != '0) && (RdW_i == e_q.rs2);

    always_ff @(posedge clk) begin
        if (rst || FlushE_i) begin
            e_q <= '0;
        end else if (StallE_i) begin
            if (refresh1) e_q.rd1 <= ResultW_i;
            if (refresh2) e_q.rd2 <= ResultW_i;
        end else begin
            e_q.rd1   <= rd1;
            e_q.rd2   <= rd2;
            e_q.rs1   <= Rs1D_i;
            e_q.rs2   <= Rs2D_i;
            e_q.rd    <= RdD_i;
            e_q.valid <= ValidD_i;
        end
    end

    assign RD1E_o   = e_q.rd1;
    assign RD2E_o   = e_q.rd2;
    assign Rs1E_o   = e_q.rs1;
    assign Rs2E_o   = e_q.rs2;
    assign RdE_o    = e_q.rd;
    assign ValidE_o = e_q.valid;

endmodule
